// File: rtl/fixed_p_std_div_seq.sv
// Sequential unsigned fixed-point divider (radix-2 restoring, one quotient bit per cycle).
// Computes floor((left << FRACT_WIDTH) / right) and saturates to all ones on divide-by-zero or overflow.
module fixed_p_std_div_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INT_WIDTH   = 8,
  parameter int unsigned FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH + FRACT_WIDTH;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_width_chk
    $error("fixed_p_std_div_seq: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_dividend;
  logic [WIDTH:0]   r_rem;
  logic [N-1:0]     r_quot;
  logic [WIDTH-1:0] r_right;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_dbz;
  logic             r_ovf;

  logic [WIDTH:0]   w_rem_shift;
  logic             w_sub;
  logic [WIDTH:0]   w_rem_next;
  logic [N-1:0]     w_quot_next;
  logic             w_last;
  logic             w_ovf;

  // One restoring step: the remainder stays below right, so WIDTH+1 bits never wrap.
  assign w_rem_shift = {r_rem[WIDTH-1:0], r_dividend[N-1]};
  assign w_sub       = (w_rem_shift >= {1'b0, r_right});
  assign w_rem_next  = w_sub ? (w_rem_shift - {1'b0, r_right}) : w_rem_shift;
  assign w_quot_next = {r_quot[N-2:0], w_sub};
  assign w_last      = (r_count == CW'(N - 1));
  assign w_ovf       = |w_quot_next[N-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_state_next = (right == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered result; result fields update only on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dividend <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_right    <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_right <= right;
            if (right == '0) begin
              r_out  <= '1;
              r_dbz  <= 1'b1;
              r_ovf  <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_dividend <= {left, {FRACT_WIDTH{1'b0}}};
              r_rem      <= '0;
              r_quot     <= '0;
              r_count    <= '0;
            end
          end
        end
        S_RUN: begin
          r_dividend <= {r_dividend[N-2:0], 1'b0};
          r_rem      <= w_rem_next;
          r_quot     <= w_quot_next;
          r_count    <= r_count + CW'(1);
          if (w_last) begin
            r_done <= 1'b1;
            r_dbz  <= 1'b0;
            r_ovf  <= w_ovf;
            r_out  <= w_ovf ? '1 : w_quot_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign out         = r_out;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fixed_p_std_div_seq.sv
// Scoreboard bench for fixed_p_std_div_seq in Q4.4 (WIDTH=8, N=12).
module tb_fixed_p_std_div_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned FW = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         go;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [W-1:0] out;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int   n_vec;
  int   n_err;
  int   cyc;
  exp_t sb_q[$];

  fixed_p_std_div_seq #(.WIDTH(W), .INT_WIDTH(IW), .FRACT_WIDTH(FW)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .left        (left),
    .right       (right),
    .out         (out),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W+FW-1:0] num;
    logic [W+FW-1:0] quo;
    exp_t            e;
    if (r == '0) begin
      e = '{q: 8'hFF, dbz: 1'b1, ovf: 1'b0};
    end else begin
      num = {l, 4'b0000};
      quo = num / {4'b0000, r};
      if (quo[W+FW-1:W] != '0) e = '{q: 8'hFF, dbz: 1'b0, ovf: 1'b1};
      else                     e = '{q: quo[W-1:0], dbz: 1'b0, ovf: 1'b0};
    end
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out", 32'(out), 32'(e.q));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] l, input logic [W-1:0] r, input int lat);
    int n;
    @(negedge clk);
    left  = l;
    right = r;
    go    = 1'b1;
    sb_q.push_back(model(l, r));
    @(negedge clk);
    go = 1'b0;
    wait_done(n);
    chk("latency", 32'(n), 32'(lat));
  endtask

  initial begin
    int n;
    int t_prev;
    logic [W-1:0] l;
    logic [W-1:0] r;
    clk   = 1'b0;
    reset = 1'b0;
    go    = 1'b0;
    left  = '0;
    right = '0;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    t_prev = 0;

    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 3.0 / 2.0 = 1.5
    run_op(8'h30, 8'h20, 12);
    // 1.0 / 3.0 truncates to 0x05, result holds afterwards
    run_op(8'h10, 8'h30, 12);
    repeat (10) @(negedge clk);
    chk("hold_out", 32'(out), 32'h05);
    chk("hold_done", 32'(done), 32'h0);
    // 15.0 / 0.0625 saturates
    run_op(8'hF0, 8'h01, 12);
    // divide by zero completes right after acceptance
    run_op(8'h25, 8'h00, 0);
    @(negedge clk);
    chk("dbz_pulse_len", 32'(done), 32'h0);
    chk("dbz_hold", 32'(div_by_zero), 32'h1);

    // Abort an op with an asynchronous reset between edges
    @(negedge clk);
    left  = 8'h30;
    right = 8'h20;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    left  = 8'h55;
    right = 8'h07;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_out", 32'(out), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_flags", 32'({div_by_zero, overflow}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    run_op(8'h30, 8'h20, 12);

    // go held high: one op per 14 cycles, mid-run operand changes ignored
    @(negedge clk);
    left  = 8'h30;
    right = 8'h20;
    go    = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back(model(8'h30, 8'h20));
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      left  = 8'($urandom);
      right = 8'($urandom_range(1, 255));
      repeat (6) @(negedge clk);
      left  = 8'h30;
      right = 8'h20;
      wait_done(n);
      chk("b2b_seen", 32'(done), 32'h1);
      if (k > 0) chk("b2b_period", 32'(cyc - t_prev), 32'd14);
      t_prev = cyc;
      if (k == 3) go = 1'b0;
    end

    // Random operands, including zero divisors
    for (int k = 0; k < 8; k++) begin
      l = 8'($urandom);
      r = (k == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      run_op(l, r, (r == 8'h00) ? 0 : 12);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_p_std_div_seq.md
Name: fixed_p_std_div_seq

Overview:
- Sequential, synthesizable unsigned fixed-point divider using a go/done handshake.
- Computes left / right for two operands of the same Q(INT_WIDTH.FRACT_WIDTH) format and returns the quotient in that format.
- Radix-2 restoring division, one quotient bit per cycle.
- Drop-in replacement for the combinational, non-synthesizable fixed-point divide. Consumes operands from the upstream add/sub/mult datapath and feeds results back into it.

Parameters:
- WIDTH, 32, total operand/result width in bits.
- INT_WIDTH, 8, integer bits; WIDTH = INT_WIDTH + FRACT_WIDTH, elaboration $error otherwise.
- FRACT_WIDTH, 24, fractional bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  start request, sampled in IDLE only.
- left  input  WIDTH  dividend, captured when go is accepted.
- right  input  WIDTH  divisor, captured when go is accepted.
- out  output  WIDTH  quotient; holds its value until the next completion.
- done  output  1  one-cycle pulse, result valid.
- div_by_zero  output  1  flag for last completed op; valid with and after done.
- overflow  output  1  quotient saturated, last completed op; valid with and after done.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; out=0, done=0, div_by_zero=0, overflow=0; counter and working registers = 0.
  - Reset mid-operation aborts the op; no done is produced.
- Let N = WIDTH + FRACT_WIDTH. Mathematical result is floor((left << FRACT_WIDTH) / right), computed over N bits.
- States:
  - IDLE: done=0.
    - go=1 at an edge captures left and right.
    - If right==0, go to DONE.
    - Otherwise load dividend = {left, FRACT_WIDTH zeros}, remainder=0, count=0, and go to RUN.
  - RUN: each edge shifts the next dividend MSB into the remainder.
    - If remainder >= right: subtract right and shift in quotient bit 1; else shift in 0.
    - count increments. At the edge where count reaches N-1 (Nth RUN edge), go to DONE.
    - go is ignored during RUN. Operand inputs may change freely.
  - DONE: done=1 for exactly one cycle, then IDLE.
    - out, div_by_zero and overflow are registered on the transition into DONE. They hold until the next transition into DONE or reset.
- Latency: go sampled at edge 0.
  - Normal op: done is high in the cycle after edge N.
  - Divide by zero: done is high in the cycle after edge 0.
- Back-to-back: go held high through DONE is not seen in DONE. It is accepted at the first edge in IDLE. Throughput is one op per N+2 cycles.
- Divide by zero: out = all ones (2^WIDTH-1), div_by_zero=1, overflow=0.
- Overflow: if any of the upper FRACT_WIDTH bits of the N-bit quotient are nonzero, out = all ones, overflow=1.
  - Otherwise out = quotient[WIDTH-1:0], overflow=0. div_by_zero=0.
- Rounding: truncation toward zero. The remainder is discarded.
- Remainder register width is WIDTH+1 so that the compare/subtract never wraps.

Test Plan:
- WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4 (N=12) for all cases below.
1. left=0x30 (3.0), right=0x20 (2.0), go pulse at edge 0 -> done high after edge 12 only; out=0x18 (1.5), overflow=0, div_by_zero=0.
2. left=0x10 (1.0), right=0x30 (3.0) -> out=0x05 (0.3125, truncated); flags 0; out still 0x05 ten cycles later with go=0.
3. left=0xF0 (15.0), right=0x01 (0.0625) -> out=0xFF, overflow=1, div_by_zero=0, done after edge 12.
4. left=0x25, right=0x00 -> done high after edge 0 for one cycle; out=0xFF, div_by_zero=1, overflow=0.
5. Start case 1; change left/right and pulse go at edge 5; assert reset low at edge 8 (asynchronously, between edges) -> out, done and flags go to 0 immediately; no done pulse ever appears; after release, a new go with 0x30/0x20 yields 0x18 in 12 cycles.
6. go held high continuously with left=0x30, right=0x20 -> done pulses every 14 cycles, each with out=0x18; operand changes made during RUN do not affect the in-flight result.
